// File: rtl/gpio_lb_pkg.sv
// gpio_lb_pkg: shared types, widths and LFSR helpers for the GPIO loopback sequencer
package gpio_lb_pkg;
    localparam int DATA_W = 16;
    localparam int BUS_W = 17;
    localparam logic [DATA_W-1:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [DATA_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] q);
        return {q[DATA_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

    function automatic logic [BUS_W-1:0] with_parity(input logic [DATA_W-1:0] d);
        return {^d, d};
    endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with synchronous load
module lfsr16 import gpio_lb_pkg::*; #(
    parameter logic [DATA_W-1:0] INIT = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              advance,
    output logic [DATA_W-1:0] q
);
    // load has priority over advance so a new run always restarts from the seed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= INIT;
        else if (load) q <= seed;
        else if (advance) q <= lfsr_next(q);
    end
endmodule

// File: rtl/gpio_loopback_seq.sv
// gpio_loopback_seq: drives LFSR vectors with even parity onto GPIOOUT and scores the looped-back GPIOIN
module gpio_loopback_seq import gpio_lb_pkg::*; #(
    parameter int                NUM_VECTORS = 16,
    parameter int                LATENCY     = 1,
    parameter logic [DATA_W-1:0] SEED        = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             inject_en,
    input  logic [7:0]       inject_idx,
    input  logic [BUS_W-1:0] GPIOIN,
    output logic [BUS_W-1:0] GPIOOUT,
    output logic             error,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       mismatch_cnt,
    output logic [7:0]       parity_err_cnt
);
    state_t            state;
    logic [7:0]        idx;
    logic [7:0]        inj_idx;
    logic              inj_en;
    logic [3:0]        settle;
    logic [DATA_W-1:0] lfsr_q;
    logic              kick;
    logic              last;
    logic              step;

    assign kick = state == IDLE && start && !abort;
    assign last = idx == 8'(NUM_VECTORS - 1);
    assign step = state == CHECK && !abort && !last;
    assign busy = state == DRIVE || state == CHECK;
    assign done = state == DONE;

    lfsr16 #(.INIT(SEED)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load   (kick),
        .seed   (SEED),
        .advance(step),
        .q      (lfsr_q)
    );

    // sequencer: drive a vector, let it settle LATENCY cycles, score the loopback, move on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            GPIOOUT        <= '0;
            error          <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= 8'h00;
            parity_err_cnt <= 8'h00;
            idx            <= 8'h00;
            inj_idx        <= 8'h00;
            inj_en         <= 1'b0;
            settle         <= 4'h0;
        end else begin
            case (state)
                IDLE: if (kick) begin
                    state          <= DRIVE;
                    mismatch_cnt   <= 8'h00;
                    parity_err_cnt <= 8'h00;
                    pass           <= 1'b0;
                    idx            <= 8'h00;
                    settle         <= 4'h0;
                    inj_en         <= inject_en;
                    inj_idx        <= inject_idx;
                    GPIOOUT        <= with_parity(SEED);
                    error          <= inject_en && inject_idx == 8'h00;
                end
                DRIVE: if (abort) begin
                    state   <= IDLE;
                    GPIOOUT <= '0;
                    error   <= 1'b0;
                end else if (settle == 4'(LATENCY - 1)) begin
                    state  <= CHECK;
                    settle <= 4'h0;
                end else begin
                    settle <= settle + 4'h1;
                end
                CHECK: if (abort) begin
                    state   <= IDLE;
                    GPIOOUT <= '0;
                    error   <= 1'b0;
                end else begin
                    if (GPIOIN[DATA_W-1:0] != GPIOOUT[DATA_W-1:0] && mismatch_cnt != 8'hFF)
                        mismatch_cnt <= mismatch_cnt + 8'h01;
                    if (^GPIOIN && parity_err_cnt != 8'hFF)
                        parity_err_cnt <= parity_err_cnt + 8'h01;
                    if (last) begin
                        state <= DONE;
                        error <= 1'b0;
                    end else begin
                        state   <= DRIVE;
                        idx     <= idx + 8'h01;
                        GPIOOUT <= with_parity(lfsr_next(lfsr_q));
                        error   <= inj_en && inj_idx == idx + 8'h01;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    pass  <= mismatch_cnt == 8'h00 && parity_err_cnt == 8'h00;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_loopback_seq.sv
// tb_gpio_loopback_seq: scoreboard bench with a behavioural vector/score model and a modelled loopback channel
module tb_gpio_loopback_seq;
    localparam int NV  = 16;
    localparam int LAT = 1;
    localparam int NVB = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, abort = 1'b0, inject_en = 1'b0;
    logic [7:0]  inject_idx = 8'h00;
    logic [16:0] gin = '0, gout;
    logic        error, busy, done, pass;
    logic [7:0]  mm_cnt, pe_cnt;

    logic        start_b = 1'b0, abort_b = 1'b0, inj_b = 1'b0;
    logic [7:0]  inj_idx_b = 8'h00;
    logic [16:0] gin_b = '0, gout_b;
    logic        error_b, busy_b, done_b, pass_b;
    logic [7:0]  mm_b, pe_b;

    int          mode = 0, mode_b = 0;
    logic [16:0] kmask = '0;
    int          vectors = 0, miscompares = 0;

    typedef struct {logic [16:0] v; logic e;} vec_t;
    typedef struct {logic [7:0] mm; logic [7:0] pe; logic pass; int errc; int busyc;} res_t;
    vec_t vec_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;

    gpio_loopback_seq u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .inject_en(inject_en),
        .inject_idx(inject_idx), .GPIOIN(gin), .GPIOOUT(gout), .error(error), .busy(busy),
        .done(done), .pass(pass), .mismatch_cnt(mm_cnt), .parity_err_cnt(pe_cnt)
    );

    gpio_loopback_seq #(.NUM_VECTORS(NVB)) u_big (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .inject_en(inj_b),
        .inject_idx(inj_idx_b), .GPIOIN(gin_b), .GPIOOUT(gout_b), .error(error_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .mismatch_cnt(mm_b), .parity_err_cnt(pe_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // loopback channel: error flips the parity bit, mode adds a test-chosen corruption
    function automatic logic [16:0] chan(input logic [16:0] o, input logic e, input int m, input logic [16:0] k);
        logic [16:0] x;
        x = o ^ {e, 16'h0000};
        case (m)
            1: x = x ^ 17'h00001;
            2: x = o[2] ? x ^ k : x;
            3: x = ~x;
            4: x = o[16] ? 17'h00000 : x;
            default: ;
        endcase
        return x;
    endfunction

    always @(posedge clk) begin
        gin   <= chan(gout, error, mode, kmask);
        gin_b <= chan(gout_b, error_b, mode_b, kmask);
    end

    function automatic logic [15:0] step_lfsr(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // reference: vector sequence, per-vector error flag and final scores of a whole run
    task automatic model_run(input int n, input int m, input logic ie, input int ii,
                             input logic [16:0] k, input bit push, output res_t r);
        logic [15:0] s;
        logic [16:0] v, in;
        logic e;
        s = 16'hACE1;
        r.mm = 0; r.pe = 0; r.errc = 0; r.busyc = n * (LAT + 1);
        for (int i = 0; i < n; i++) begin
            v = {^s, s};
            e = ie && ii == i;
            if (push) vec_q.push_back('{v, e});
            in = chan(v, e, m, k);
            if (in[15:0] != s && r.mm != 8'hFF) r.mm++;
            if (^in && r.pe != 8'hFF) r.pe++;
            if (e) r.errc += LAT + 1;
            s = step_lfsr(s);
        end
        r.pass = r.mm == 0 && r.pe == 0;
    endtask

    // monitor: pops expected vectors when a new one is driven and results when done pulses
    logic        prev_busy = 1'b0, cur_err = 1'b0, pass_pend = 1'b0, exp_pass = 1'b0;
    logic [16:0] prev_out = '0;
    int          errc = 0, busyc = 0;
    always @(negedge clk) begin
        vec_t x;
        res_t r;
        if (pass_pend) check("pass", pass, exp_pass);
        pass_pend = 1'b0;
        if (busy) begin
            if (!prev_busy) begin errc = 0; busyc = 0; end
            if (!prev_busy || gout != prev_out) begin
                check("vector queued", vec_q.size() != 0, 1);
                if (vec_q.size() != 0) begin
                    x = vec_q.pop_front();
                    check("GPIOOUT", gout, x.v);
                    cur_err = x.e;
                end
            end
            check("error flag", error, cur_err);
            errc += int'(error);
            busyc++;
        end
        if (done) begin
            check("result queued", res_q.size() != 0, 1);
            if (res_q.size() != 0) begin
                r = res_q.pop_front();
                check("mismatch_cnt", mm_cnt, r.mm);
                check("parity_err_cnt", pe_cnt, r.pe);
                check("error cycles", errc, r.errc);
                check("busy cycles", busyc, r.busyc);
                exp_pass = r.pass;
                pass_pend = 1'b1;
            end
        end
        prev_busy = busy;
        prev_out = gout;
    end

    task automatic run_small(input int m, input logic ie, input logic [7:0] ii, input logic [16:0] k);
        res_t r;
        model_run(NV, m, ie, int'(ii), k, 1, r);
        res_q.push_back(r);
        mode = m; kmask = k; inject_en = ie; inject_idx = ii;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("first vector", gout, 17'h0ACE1);
        for (int t = 0; t < 400 && (res_q.size() != 0 || pass_pend); t++) @(negedge clk);
        check("run completed", res_q.size(), 0);
        res_q.delete();
        vec_q.delete();
    endtask

    task automatic run_big(input int m);
        res_t r;
        int t;
        model_run(NVB, m, 1'b0, 0, '0, 0, r);
        mode_b = m;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        t = 0;
        while (!done_b && t < 2000) begin @(negedge clk); t++; end
        check("big done", done_b, 1);
        check("big mismatch_cnt", mm_b, r.mm);
        check("big parity_err_cnt", pe_b, r.pe);
        @(negedge clk) check("big pass", pass_b, r.pass);
    endtask

    initial begin
        res_t r;
        logic p0;
        repeat (3) @(negedge clk);
        check("reset GPIOOUT", gout, 0);
        check("reset error", error, 0);
        check("reset done", done, 0);
        check("reset pass", pass, 0);
        check("reset counters", {mm_cnt, pe_cnt}, 0);
        check("reset busy", busy, 0);
        reset = 1'b0;

        run_small(0, 1'b0, 8'd0, '0);
        run_small(0, 1'b1, 8'd3, '0);
        check("inject parity_err_cnt", pe_cnt, 1);
        check("inject mismatch_cnt", mm_cnt, 0);
        run_small(1, 1'b0, 8'd0, '0);
        check("bit0 mismatch_cnt", mm_cnt, 16);
        check("bit0 parity_err_cnt", pe_cnt, 16);
        run_small(0, 1'b1, 8'd200, '0);
        for (int i = 0; i < 6; i++)
            run_small(int'($urandom_range(0, 2)), 1'($urandom), 8'($urandom_range(0, 20)), 17'($urandom));

        run_big(4);
        run_big(3);
        check("saturated parity_err_cnt", pe_b, 8'hFF);
        check("saturated mismatch_cnt", mm_b, 8'hFF);

        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check("abort beats start", busy, 0);
        repeat (2) @(negedge clk);
        check("still idle", busy, 0);

        p0 = pass;
        mode = 0; inject_en = 1'b0;
        model_run(3, 0, 1'b0, 0, '0, 1, r);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("abort GPIOOUT", gout, 0);
        check("abort busy", busy, 0);
        check("abort error", error, 0);
        check("abort done", done, 0);
        repeat (4) @(negedge clk);
        check("abort vectors seen", vec_q.size(), 0);
        check("abort pass held", pass, p0);
        vec_q.delete();
        run_small(0, 1'b0, 8'd0, '0);

        model_run(2, 0, 1'b0, 0, '0, 1, r);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid reset GPIOOUT", gout, 0);
        check("mid reset error", error, 0);
        check("mid reset busy", busy, 0);
        check("mid reset done", done, 0);
        check("mid reset pass", pass, 0);
        check("mid reset counters", {mm_cnt, pe_cnt}, 0);
        @(negedge clk) reset = 1'b0;
        vec_q.delete();
        run_small(0, 1'b0, 8'd0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
